// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath access into a held memory request,
// aligns byte lanes, writes load results back, and aborts on misalignment or timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ram_data2,
  output logic [3:0]  w_addr1,
  output logic        w_en1,
  output logic        sel_w_data,
  output logic        stall,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  rd_r, be_r;
  logic        store_r, fault_r;
  logic [7:0]  cnt;
  logic        accept, misalign;
  logic [31:0] load_val;

  assign accept   = req_valid && (state == IDLE);
  assign misalign = !req_byte && (req_addr[1:0] != 2'b00);

  // Byte loads zero-extend the lane picked by the low address bits.
  assign load_val = (be_r == 4'b1111) ? mem_rdata
                  : {24'h0, mem_rdata[{addr_r[1:0], 3'b000} +: 8]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && !misalign) state_nx = REQ;
      REQ: begin
        if (mem_ack)             state_nx = store_r ? IDLE : WB;
        else if (cnt == TO_LAST) state_nx = IDLE;
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      rd_r    <= '0;
      be_r    <= '0;
      store_r <= 1'b0;
      fault_r <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      fault_r <= 1'b0;
      if (accept) begin
        if (misalign) begin
          fault_r <= 1'b1;
        end else begin
          addr_r  <= req_addr;
          rd_r    <= req_rd;
          store_r <= req_store;
          be_r    <= req_byte ? (4'b0001 << req_addr[1:0]) : 4'b1111;
          wdata_r <= req_byte ? {4{req_wdata[7:0]}} : req_wdata;
          cnt     <= '0;
        end
      end
      if (state == REQ) begin
        if (mem_ack) begin
          if (!store_r) rdata_r <= load_val;
        end else if (cnt == TO_LAST) begin
          fault_r <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign stall      = (state != IDLE);
  assign mem_req    = (state == REQ);
  assign mem_we     = (state == REQ) && store_r;
  assign mem_be     = (state == REQ) ? be_r : 4'b0000;
  assign mem_addr   = addr_r[31:2];
  assign mem_wdata  = wdata_r;
  assign ram_data2  = rdata_r;
  assign w_addr1    = rd_r;
  assign w_en1      = (state == WB);
  assign sel_w_data = (state == WB);
  assign fault      = fault_r;
endmodule
